operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Decode->execute boundary stage. Accepts one decoded instruction per cycle and drives rs1/rs2 to the
//  register file. Resolves operands with EX/MEM/WB forwarding and stalls on load-use hazards.
//  Registers the result into a valid/ready pipeline register that feeds the execute stage.
// PARAMETERS
//  CTRL_W   16   width of opaque decoded-control bundle, passed through untouched
//  XLEN     64   datapath width; must match the register file
// PORTS
//  clk           in   1       core clock
//  rst_n         in   1       asynchronous active-low reset
//  flush         in   1       kill the input and output instructions (branch redirect)
//  in_valid      in   1       decoded instruction present
//  in_ready      out  1       stage accepts the instruction this cycle
//  in_pc         in   XLEN    instruction PC
//  in_rs1        in   5       source register 1 index
//  in_rs2        in   5       source register 2 index
//  in_rd         in   5       destination register index
//  in_uses_rs1   in   1       rs1 is a real source (hazard/forward qualifier)
//  in_uses_rs2   in   1       rs2 is a real source
//  in_imm        in   XLEN    sign-extended immediate
//  in_ctrl       in   CTRL_W  decoded control bundle
//  rf_rs1        out  5       regfile read index 1 (= in_rs1, combinational)
//  rf_rs2        out  5       regfile read index 2 (= in_rs2, combinational)
//  rf_rs1_data   in   XLEN    regfile read data 1 (x0 reads 0)
//  rf_rs2_data   in   XLEN    regfile read data 2
//  ex_valid      in   1       EX stage holds an instruction writing ex_rd
//  ex_is_load    in   1       that EX instruction is a load (result not yet available)
//  ex_rd         in   5       EX destination
//  ex_data       in   XLEN    EX ALU result
//  mem_valid     in   1       MEM stage result valid for mem_rd (includes load data)
//  mem_rd        in   5       MEM destination
//  mem_data      in   XLEN    MEM result
//  wb_we         in   1       writeback enable (same signal driving regfile rd_we)
//  wb_rd         in   5       writeback destination
//  wb_data       in   XLEN    writeback data
//  out_valid     out  1       operand bundle valid for execute
//  out_ready     in   1       execute accepts the bundle
//  out_pc/out_imm out XLEN    registered copies
//  out_rs1_val   out  XLEN    resolved operand 1
//  out_rs2_val   out  XLEN    resolved operand 2
//  out_rd        out  5       registered destination
//  out_ctrl      out  CTRL_W  registered control bundle
//  stall_cnt     out  32      load-use stall cycles since reset, saturating
// BEHAVIOUR
//  Reset: out_valid=0; all out_* data=0; stall_cnt=0. in_ready is combinational and 0 while rst_n=0.
//  Forwarding per operand, priority EX > MEM > WB > RF. Match = valid & rd==src & src!=0.
//  EX matches only if !ex_is_load. Index 0 always yields 0. WB bypass is mandatory: the regfile
//  writes at the clock edge, so its read port shows stale data in the write cycle.
//  Hazard = in_valid & ((uses_rs1 & rs1!=0 & rs1==ex_rd) | same for rs2) & ex_valid & ex_is_load.
//  adv = !out_valid | out_ready (the output register may load).
//  in_ready = adv & !hazard & !flush. Fire = in_valid & in_ready. Latency: 1 cycle, fire -> out_valid.
//  Each edge, in priority order:
//   - flush:          out_valid<=0.
//   - fire:           out_valid<=1 and all out_* captured, including the forwarded operands.
//   - adv & !fire:    out_valid<=0 (bubble; covers hazard and !in_valid).
//   - otherwise:      hold. out_* stay stable while out_valid & !out_ready.
//  stall_cnt increments in each cycle where hazard & adv & !flush, and saturates at 2^32-1.
//  Load-use gives exactly one bubble: the next cycle the load is in MEM and forwards via mem_valid.
//  If mem_valid=0 in that cycle, the upstream valid-qualified source produces no match and RF data is
//  used. Upstream must hold ex_valid/ex_is_load while load data is pending.
//  Reset mid-operation: the in-flight bundle is discarded with no partial output.
// STRUCTURE
//  core_pkg: XLEN, CTRL_W default, typedef fwd_sel_e {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
//  Sub-module operand_bypass, instantiated twice: purely combinational, takes src index, RF data and
//  the three forward ports; returns the value plus fwd_sel_e for debug.
//  Top level holds the hazard logic, the output register and stall_cnt.
// TESTING
//  1. rs1=5, RF[5]=0x10, no forwards -> next cycle out_valid=1, out_rs1_val=0x10.
//  2. EX rd=5 data=0xAA, MEM rd=5 data=0xBB, WB rd=5 data=0xCC -> out_rs1_val=0xAA.
//     Remove EX -> 0xBB; remove MEM -> 0xCC.
//  3. ex_valid, ex_is_load, ex_rd=7; in rs2=7 uses_rs2 -> in_ready=0 for 1 cycle, stall_cnt=1.
//     Next cycle mem rd=7 data=0x55 -> out_rs2_val=0x55.
//  4. rs1=0 while EX/MEM/WB all target rd=0 with nonzero data -> out_rs1_val=0, no stall.
//  5. out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; release -> next instr fires.
//  6. flush during fire plus rst_n pulse mid-stream -> out_valid=0 next cycle, stall_cnt=0 after reset.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand-fetch stage: register index, forwarding source
// selector and the valid/index match rule used by every bypass comparison.
package operand_fetch_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned CTRL_W_DEF = 16;
    localparam int unsigned REG_IDX_W  = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    // x0 never matches: it is hardwired to zero regardless of any producer.
    function automatic logic fwd_match(input logic valid, input reg_idx_t rd, input reg_idx_t src);
        return valid && (rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side handshake bundles of the operand-fetch stage.
// master = surrounding pipeline, slave = operand_fetch.
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned CTRL_W = CTRL_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    reg_idx_t          in_rs1;
    reg_idx_t          in_rs2;
    reg_idx_t          in_rd;
    logic              in_uses_rs1;
    logic              in_uses_rs2;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;
    reg_idx_t          out_rd;
    logic [CTRL_W-1:0] out_ctrl;
    fwd_sel_e          out_rs1_fwd;
    fwd_sel_e          out_rs2_fwd;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2, in_imm, in_ctrl,
        output out_ready,
        input  in_ready,
        input  out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
        input  out_rs1_fwd, out_rs2_fwd
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2, in_imm, in_ctrl,
        input  out_ready,
        output in_ready,
        output out_valid, out_pc, out_imm, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
        output out_rs1_fwd, out_rs2_fwd
    );

endinterface

// File: rtl/operand_fetch_bypass.sv
// Per-operand forwarding mux: picks EX > MEM > WB > regfile, x0 always zero.
// Purely combinational; also reports which source won for debug.
module operand_fetch_bypass
    import operand_fetch_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  reg_idx_t        src_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            ex_valid_i,
    input  logic            ex_is_load_i,
    input  reg_idx_t        ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            mem_valid_i,
    input  reg_idx_t        mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_we_i,
    input  reg_idx_t        wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] val_o,
    output fwd_sel_e        sel_o
);

    always_comb begin
        val_o = rf_data_i;
        sel_o = FWD_RF;
        if (src_i == '0) begin
            val_o = '0;
        end else if (fwd_match(ex_valid_i && !ex_is_load_i, ex_rd_i, src_i)) begin
            // A load in EX has no data yet; the hazard logic stalls instead.
            val_o = ex_data_i;
            sel_o = FWD_EX;
        end else if (fwd_match(mem_valid_i, mem_rd_i, src_i)) begin
            val_o = mem_data_i;
            sel_o = FWD_MEM;
        end else if (fwd_match(wb_we_i, wb_rd_i, src_i)) begin
            val_o = wb_data_i;
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Decode->execute boundary: drives regfile reads, resolves operands with
// forwarding, stalls on load-use and registers the bundle behind valid/ready.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned XLEN   = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    operand_fetch_if.slave  io,
    output reg_idx_t        rf_rs1,
    output reg_idx_t        rf_rs2,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            ex_valid,
    input  logic            ex_is_load,
    input  reg_idx_t        ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_valid,
    input  reg_idx_t        mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  reg_idx_t        wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0]   rs1_val, rs2_val;
    fwd_sel_e          rs1_sel, rs2_sel;
    logic              hazard, adv, in_ready, fire;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d;
    logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
    reg_idx_t          rd_q, rd_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    fwd_sel_e          rs1_sel_q, rs1_sel_d, rs2_sel_q, rs2_sel_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    assign rf_rs1 = io.in_rs1;
    assign rf_rs2 = io.in_rs2;

    operand_fetch_bypass #(.XLEN(XLEN)) u_byp_rs1 (
        .src_i(io.in_rs1), .rf_data_i(rf_rs1_data),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .mem_valid_i(mem_valid), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .val_o(rs1_val), .sel_o(rs1_sel)
    );

    operand_fetch_bypass #(.XLEN(XLEN)) u_byp_rs2 (
        .src_i(io.in_rs2), .rf_data_i(rf_rs2_data),
        .ex_valid_i(ex_valid), .ex_is_load_i(ex_is_load), .ex_rd_i(ex_rd), .ex_data_i(ex_data),
        .mem_valid_i(mem_valid), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .val_o(rs2_val), .sel_o(rs2_sel)
    );

    always_comb begin
        hazard   = io.in_valid && ex_valid && ex_is_load &&
                   ((io.in_uses_rs1 && fwd_match(1'b1, ex_rd, io.in_rs1)) ||
                    (io.in_uses_rs2 && fwd_match(1'b1, ex_rd, io.in_rs2)));
        adv      = !out_valid_q || io.out_ready;
        in_ready = rst_n && adv && !hazard && !flush;
        fire     = io.in_valid && in_ready;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        ctrl_d      = ctrl_q;
        rs1_sel_d   = rs1_sel_q;
        rs2_sel_d   = rs2_sel_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d = 1'b1;
            pc_d        = io.in_pc;
            imm_d       = io.in_imm;
            rs1_d       = rs1_val;
            rs2_d       = rs2_val;
            rd_d        = io.in_rd;
            ctrl_d      = io.in_ctrl;
            rs1_sel_d   = rs1_sel;
            rs2_sel_d   = rs2_sel;
        end else if (adv) begin
            out_valid_d = 1'b0;
        end

        // Only stalls that actually block a loadable output register are counted.
        if (hazard && adv && !flush && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            rs1_sel_q   <= FWD_RF;
            rs2_sel_q   <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
            rs1_sel_q   <= rs1_sel_d;
            rs2_sel_q   <= rs2_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io.in_ready    = in_ready;
    assign io.out_valid   = out_valid_q;
    assign io.out_pc      = pc_q;
    assign io.out_imm     = imm_q;
    assign io.out_rs1_val = rs1_q;
    assign io.out_rs2_val = rs2_q;
    assign io.out_rd      = rd_q;
    assign io.out_ctrl    = ctrl_q;
    assign io.out_rs1_fwd = rs1_sel_q;
    assign io.out_rs2_fwd = rs2_sel_q;
    assign stall_cnt      = stall_cnt_q;

endmodule
